// File: rtl/game_tick_gen.sv
// game_tick_gen: NUM_CH gated tick channels with per-channel period and speed scaling.
// Define GAME_TICK_ACCEL_EN to enable progressive acceleration driven by channel 0.
module game_tick_gen #(
   parameter int NUM_CH     = 2,
   parameter int CNT_W      = 21,
   parameter int ACCEL_STEP = 1000,
   parameter int ACCEL_MAX  = 500000
) (
   input  logic                    system_clk,
   input  logic                    nreset,
   input  logic [1:0]              game_state,
   input  logic [1:0]              game_speed,
   input  logic [NUM_CH*CNT_W-1:0] ch_period,
   input  logic [NUM_CH-1:0]       speed_mask,
   output logic [NUM_CH-1:0]       tick,
   output logic                    run_en,
   output logic [15:0]             tick_total
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_PAUSE = 2'd2,
      ST_END   = 2'd3
   } game_state_e;

   typedef enum logic [1:0] {
      SP_NORMAL = 2'd0,
      SP_FAST   = 2'd1,
      SP_SLOW   = 2'd2,
      SP_RSVD   = 2'd3
   } game_speed_e;

   localparam logic [CNT_W:0] EFF_MAX = {1'b0, {CNT_W{1'b1}}};
   localparam logic [CNT_W:0] EFF_ONE = (CNT_W+1)'(1);

   game_state_e st;
   game_speed_e sp;
   logic        is_run;
   logic        is_wait;

   logic [CNT_W-1:0] cnt_q [NUM_CH];
   logic [CNT_W-1:0] lp_q  [NUM_CH];
   logic [CNT_W-1:0] eff   [NUM_CH];
   logic [NUM_CH-1:0] wrap;

   logic [CNT_W:0] b;
   logic [CNT_W:0] s;
   logic [CNT_W:0] r;

   assign st      = game_state_e'(game_state);
   assign sp      = game_speed_e'(game_speed);
   assign is_run  = (st == ST_RUN);
   assign is_wait = (st == ST_WAIT);

`ifdef GAME_TICK_ACCEL_EN
   logic [31:0] off_q;
   logic [31:0] off_nxt;
   logic [32:0] off_sum;

   // The offset bumped by this channel-0 tick already shapes the period latched with it.
   always_comb begin
      off_sum = {1'b0, off_q} + 33'(ACCEL_STEP);
      off_nxt = off_q;
      if (is_wait) begin
         off_nxt = '0;
      end else if (is_run && wrap[0]) begin
         if (off_sum >= 33'(ACCEL_MAX)) begin
            off_nxt = 32'(ACCEL_MAX);
         end else begin
            off_nxt = off_sum[31:0];
         end
      end
   end

   always_ff @(posedge system_clk or negedge nreset) begin
      if (!nreset) begin
         off_q <= '0;
      end else begin
         off_q <= off_nxt;
      end
   end
`endif

   always_comb begin
      b = '0;
      s = '0;
      r = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         b = {1'b0, ch_period[k*CNT_W +: CNT_W]};
         s = b;
         if (speed_mask[k]) begin
            unique case (sp)
               SP_FAST: s = b >> 1;
               SP_SLOW: s = b[CNT_W-1] ? EFF_MAX : (b << 1);
               default: s = b;
            endcase
         end
         r = s;
`ifdef GAME_TICK_ACCEL_EN
         if (speed_mask[k]) begin
            if (33'(s) <= {1'b0, off_nxt}) begin
               r = '0;
            end else begin
               r = s - off_nxt[CNT_W:0];
            end
         end
`endif
         if (r == '0) begin
            r = EFF_ONE;
         end else if (r > EFF_MAX) begin
            r = EFF_MAX;
         end
         eff[k] = r[CNT_W-1:0];
      end
   end

   always_comb begin
      wrap = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         wrap[k] = (cnt_q[k] == lp_q[k] - CNT_W'(1));
      end
   end

   always_ff @(posedge system_clk or negedge nreset) begin
      if (!nreset) begin
         for (int k = 0; k < NUM_CH; k++) begin
            cnt_q[k] <= '0;
            lp_q[k]  <= CNT_W'(1);
         end
         tick       <= '0;
         run_en     <= 1'b0;
         tick_total <= '0;
      end else begin
         run_en <= is_run;
         unique case (1'b1)
            is_wait: begin
               for (int k = 0; k < NUM_CH; k++) begin
                  cnt_q[k] <= '0;
                  lp_q[k]  <= eff[k];
               end
               tick       <= '0;
               tick_total <= '0;
            end
            is_run: begin
               for (int k = 0; k < NUM_CH; k++) begin
                  if (wrap[k]) begin
                     cnt_q[k] <= '0;
                     lp_q[k]  <= eff[k];
                  end else begin
                     cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                  end
               end
               tick <= wrap;
               if (wrap[0]) begin
                  tick_total <= tick_total + 16'd1;
               end
            end
            default: begin
               tick <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_tick_gen.sv
// tb_game_tick_gen: scoreboard bench for game_tick_gen (NUM_CH=2, CNT_W=8).
// Expected outputs are queued as stimulus is driven and compared after each edge.
module tb_game_tick_gen;

   localparam int NUM_CH = 2;
   localparam int CNT_W  = 8;

   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] WAIT     = 2'd1;
   localparam logic [1:0] PAUSE    = 2'd2;
   localparam logic [1:0] END_GAME = 2'd3;

   localparam logic [1:0] NORMAL = 2'd0;
   localparam logic [1:0] FAST   = 2'd1;
   localparam logic [1:0] SLOW   = 2'd2;

   logic                    system_clk = 1'b0;
   logic                    nreset = 1'b0;
   logic [1:0]              game_state = WAIT;
   logic [1:0]              game_speed = NORMAL;
   logic [NUM_CH*CNT_W-1:0] ch_period = '0;
   logic [NUM_CH-1:0]       speed_mask = '0;
   logic [NUM_CH-1:0]       tick;
   logic                    run_en;
   logic [15:0]             tick_total;

   typedef struct packed {
      logic [1:0]  tick;
      logic        run_en;
      logic [15:0] total;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   int checks = 0;
   int errors = 0;
   int n  = 0;
   int p0 = 1;
   int p1 = 1;

   game_tick_gen #(
      .NUM_CH     (NUM_CH),
      .CNT_W      (CNT_W),
      .ACCEL_STEP (2),
      .ACCEL_MAX  (6)
   ) dut (
      .system_clk (system_clk),
      .nreset     (nreset),
      .game_state (game_state),
      .game_speed (game_speed),
      .ch_period  (ch_period),
      .speed_mask (speed_mask),
      .tick       (tick),
      .run_en     (run_en),
      .tick_total (tick_total)
   );

   always #5 system_clk = ~system_clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(posedge system_clk) begin
      #1;
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         chk("tick", 32'(tick), 32'(mon_e.tick));
         chk("run_en", 32'(run_en), 32'(mon_e.run_en));
         chk("tick_total", 32'(tick_total), 32'(mon_e.total));
      end
   end

   task automatic drive(input logic [1:0] st, input logic [1:0] et,
                        input logic [15:0] etot);
      exp_t e;
      game_state = st;
      e.tick   = et;
      e.run_en = (st == RUN);
      e.total  = etot;
      sb_q.push_back(e);
      @(negedge system_clk);
   endtask

   task automatic run_n(input int k);
      for (int i = 0; i < k; i++) begin
         n++;
         drive(RUN, {(n % p1) == 0, (n % p0) == 0}, 16'(n / p0));
      end
   endtask

   task automatic idle_n(input logic [1:0] st, input int k);
      for (int i = 0; i < k; i++) begin
         if (st == WAIT) n = 0;
         drive(st, 2'b00, 16'(n / p0));
      end
   endtask

   initial begin
      int c;
      int nxt;
      int off;
      int per;
      int cnt0;
      logic t0;

      #12;
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_run_en", 32'(run_en), 32'd0);
      chk("rst_total", 32'(tick_total), 32'd0);
      @(negedge system_clk);
      nreset = 1'b1;

      // base periods, coincident ticks, tick_total
      ch_period = {8'd10, 8'd4};
      p0 = 4;
      p1 = 10;
      idle_n(WAIT, 3);
      run_n(40);
      chk("s1_total", 32'(tick_total), 32'd10);

      // pause resumes mid-period, wait restarts
      ch_period = {8'd4, 8'd6};
      p0 = 6;
      p1 = 4;
      idle_n(WAIT, 2);
      run_n(3);
      idle_n(PAUSE, 5);
      run_n(2);
      idle_n(PAUSE, 1);
      run_n(7);
      idle_n(END_GAME, 3);
      run_n(5);
      idle_n(WAIT, 2);
      run_n(3);
      idle_n(WAIT, 2);
      chk("wait_total", 32'(tick_total), 32'd0);
      run_n(7);

      // asynchronous reset mid-period
      idle_n(WAIT, 1);
      run_n(8);
      #2;
      nreset = 1'b0;
      #1;
      chk("arst_tick", 32'(tick), 32'd0);
      chk("arst_run_en", 32'(run_en), 32'd0);
      chk("arst_total", 32'(tick_total), 32'd0);
      @(negedge system_clk);
      nreset = 1'b1;
      idle_n(WAIT, 2);
      run_n(13);

      // speed scaling: SLOW saturates, FAST waits for the wrap
      ch_period = {8'd7, 8'd200};
      speed_mask = 2'b01;
      game_speed = SLOW;
      idle_n(WAIT, 2);
      nxt = 255;
      off = 0;
      cnt0 = 0;
      for (c = 1; c <= 460; c++) begin
         if (c == 10) game_speed = FAST;
         t0 = (c == nxt);
         if (t0) begin
            cnt0++;
`ifdef GAME_TICK_ACCEL_EN
            off = (off + 2 > 6) ? 6 : off + 2;
`endif
            nxt += 100 - off;
         end
         drive(RUN, {(c % 7) == 0, t0}, 16'(cnt0));
      end
      game_speed = NORMAL;

`ifdef GAME_TICK_ACCEL_EN
      // acceleration on masked channel 0 only
      ch_period = {8'd5, 8'd10};
      speed_mask = 2'b01;
      idle_n(WAIT, 2);
      nxt = 10;
      per = 10;
      cnt0 = 0;
      for (c = 1; c <= 40; c++) begin
         t0 = (c == nxt);
         if (t0) begin
            cnt0++;
            per = (per - 2 < 4) ? 4 : per - 2;
            nxt += per;
         end
         drive(RUN, {(c % 5) == 0, t0}, 16'(cnt0));
      end
      idle_n(WAIT, 1);
      for (c = 1; c <= 12; c++) begin
         drive(RUN, {(c % 5) == 0, c == 10}, (c >= 10) ? 16'd1 : 16'd0);
      end
`endif

      // period 0 clamps to 1; tick_total wraps
      ch_period = '0;
      speed_mask = 2'b00;
      p0 = 1;
      p1 = 1;
      idle_n(WAIT, 1);
      run_n(65536);
      chk("wrap_total", 32'(tick_total), 32'd0);

      idle_n(PAUSE, 1);
      repeat (2) @(negedge system_clk);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
